// File: rtl/pbkdf2_iter_ctrl.sv
// PBKDF2-HMAC-SHA256 iteration controller.
// Drives a single HMAC-SHA256 engine through the U1..Uc chain for one
// 256-bit output block and XOR-accumulates the results into dk_o.
module pbkdf2_iter_ctrl #(
  parameter int ITER_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // host-facing request
  input  logic [511:0]      password_i,
  input  logic [511:0]      salt_i,
  input  logic [5:0]        salt_len_i,
  input  logic [ITER_W-1:0] iter_i,
  input  logic              v_i,
  output logic              r_o,
  // host-facing result
  output logic [255:0]      dk_o,
  output logic              err_o,
  output logic              v_o,
  input  logic              r_i,
  // HMAC engine request
  output logic [511:0]      hmac_key_o,
  output logic [511:0]      hmac_msg_o,
  output logic [5:0]        hmac_len_o,
  output logic              hmac_v_o,
  input  logic              hmac_r_i,
  // HMAC engine result
  input  logic [255:0]      hmac_prf_i,
  input  logic              hmac_v_i,
  output logic              hmac_r_o
);

  // Longest salt that still leaves room for the 4-byte block index
  // inside a single-block HMAC message (51 + 4 = 55 bytes).
  localparam logic [5:0] MAX_SALT_LEN = 6'd51;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [511:0]      key_q;
  logic [511:0]      salt_q;
  logic [5:0]        slen_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] j_q;
  logic [255:0]      acc_q;
  logic [255:0]      u_q;
  logic              err_q;

  logic              req_fire;
  logic              len_bad;
  logic              first_iter;
  logic              last_iter;
  logic [8:0]        salt_shift;
  logic [511:0]      salt_mask;
  logic [511:0]      index_blk;

  assign req_fire   = v_i && (state_q == IDLE);
  assign len_bad    = (salt_len_i > MAX_SALT_LEN);
  assign first_iter = (j_q == ITER_W'(1));
  // Full-width compare: j stops at c, so c = 2^ITER_W-1 never wraps.
  assign last_iter  = (j_q == iter_q);

  // Keep only the first salt_len_i bytes of the left-aligned salt.
  assign salt_shift = {salt_len_i, 3'b000};
  assign salt_mask  = ~({512{1'b1}} >> salt_shift);

  // INT(1) placed directly after the last salt byte.
  assign index_blk  = {32'h0000_0001, 480'b0} >> {slen_q, 3'b000};

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and handshake outputs.
  // NOTE: every output gets a default before the case so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    r_o      = 1'b0;
    v_o      = 1'b0;
    hmac_v_o = 1'b0;
    hmac_r_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        r_o = 1'b1;
        if (v_i) state_d = len_bad ? DONE : SEND;
      end
      SEND: begin
        hmac_v_o = 1'b1;
        if (hmac_r_i) state_d = WAIT;
      end
      WAIT: begin
        hmac_r_o = 1'b1;
        if (hmac_v_i) state_d = last_iter ? DONE : SEND;
      end
      DONE: begin
        v_o = 1'b1;
        if (r_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, iteration counter, U register and XOR accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_q  <= '0;
      salt_q <= '0;
      slen_q <= '0;
      iter_q <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      u_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      if (req_fire) begin
        key_q  <= password_i;
        salt_q <= salt_i & salt_mask;
        slen_q <= salt_len_i;
        iter_q <= (iter_i == '0) ? ITER_W'(1) : iter_i;
        j_q    <= ITER_W'(1);
        acc_q  <= '0;
        err_q  <= len_bad;
      end
      if (state_q == WAIT && hmac_v_i) begin
        u_q   <= hmac_prf_i;
        acc_q <= acc_q ^ hmac_prf_i;
        if (!last_iter) j_q <= j_q + ITER_W'(1);
      end
    end
  end

  // Request fields come straight from registers that only change in IDLE
  // and WAIT, so they hold steady for the whole SEND phase.
  assign hmac_key_o = key_q;
  assign hmac_msg_o = first_iter ? (salt_q | index_blk) : {u_q, 256'b0};
  assign hmac_len_o = first_iter ? (slen_q + 6'd4) : 6'd32;

  assign dk_o  = acc_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_pbkdf2_iter_ctrl.sv
// Self-checking bench for pbkdf2_iter_ctrl: a behavioural HMAC-SHA256
// engine answers the controller, and expected derived keys (RFC 6070
// style vectors) are queued at request time and checked on v_o.
module tb_pbkdf2_iter_ctrl;

  localparam int ITER_W = 32;

  localparam logic [255:0] DK_C1    = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [255:0] DK_C2    = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
  localparam logic [255:0] DK_C4096 = 256'hc5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a;
  localparam logic [511:0] PW       = {64'h70617373776f7264, 448'h0};          // "password"
  localparam logic [511:0] SALT     = {32'h73616c74, {15{32'hdeadbeef}}};      // "salt" + junk

  localparam logic [31:0] SHA_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] SHA_H0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [511:0]      password_i;
  logic [511:0]      salt_i;
  logic [5:0]        salt_len_i;
  logic [ITER_W-1:0] iter_i;
  logic              v_i;
  logic              r_o;
  logic [255:0]      dk_o;
  logic              err_o;
  logic              v_o;
  logic              r_i;
  logic [511:0]      hmac_key_o;
  logic [511:0]      hmac_msg_o;
  logic [5:0]        hmac_len_o;
  logic              hmac_v_o;
  logic              hmac_r_i;
  logic [255:0]      hmac_prf_i;
  logic              hmac_v_i;
  logic              hmac_r_o;

  pbkdf2_iter_ctrl #(.ITER_W(ITER_W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .password_i (password_i),
    .salt_i     (salt_i),
    .salt_len_i (salt_len_i),
    .iter_i     (iter_i),
    .v_i        (v_i),
    .r_o        (r_o),
    .dk_o       (dk_o),
    .err_o      (err_o),
    .v_o        (v_o),
    .r_i        (r_i),
    .hmac_key_o (hmac_key_o),
    .hmac_msg_o (hmac_msg_o),
    .hmac_len_o (hmac_len_o),
    .hmac_v_o   (hmac_v_o),
    .hmac_r_i   (hmac_r_i),
    .hmac_prf_i (hmac_prf_i),
    .hmac_v_i   (hmac_v_i),
    .hmac_r_o   (hmac_r_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard and counters ----------------
  typedef struct packed {
    logic         err;
    logic [255:0] dk;
  } exp_t;

  exp_t         sb_q[$];
  logic [511:0] log_msg[$];
  logic [5:0]   log_len[$];

  int n_cmp = 0;
  int n_mis = 0;
  int n_req = 0;
  int n_res = 0;
  int stab_err = 0;
  int ost_err = 0;
  int hold_err = 0;
  int hv_seen = 0;
  int acc_cyc = 0;
  int last_lat = 0;
  bit stall_mode = 1'b0;
  int lat_n = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SHA-256 / HMAC reference ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
            e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
  endfunction

  // HMAC-SHA256 for a 64-byte zero-padded key and a message of <= 55 bytes.
  function automatic logic [255:0] hmac_ref(input logic [511:0] key, input logic [511:0] msg, input logic [5:0] len);
    logic [511:0] blk;
    logic [511:0] pad80;
    logic [255:0] st, inner;
    pad80 = {8'h80, 504'b0};
    st    = sha_compress(SHA_H0, key ^ {64{8'h36}});
    blk   = msg | (pad80 >> (8 * int'(len)));
    blk[63:0] = 64'((64 + int'(len)) * 8);
    inner = sha_compress(st, blk);
    st    = sha_compress(SHA_H0, key ^ {64{8'h5c}});
    return sha_compress(st, {inner, 8'h80, 184'b0, 64'd768});
  endfunction

  // ---------------- behavioural HMAC engine ----------------
  initial begin
    bit           req_x, res_x, busy, held_v;
    logic [1029:0] snap;
    logic [511:0] cap_key, cap_msg;
    logic [5:0]   cap_len;
    logic [255:0] pend;
    int           dly;
    hmac_r_i = 1'b0; hmac_v_i = 1'b0; hmac_prf_i = '0;
    busy = 1'b0; held_v = 1'b0; dly = 0; snap = '0; pend = '0;
    cap_key = '0; cap_msg = '0; cap_len = '0;
    forever begin
      @(negedge clk_i);
      req_x = hmac_v_o && hmac_r_i;
      res_x = hmac_v_i && hmac_r_o;
      if (hmac_v_o) hv_seen++;
      if (hmac_v_o && held_v && ({hmac_key_o, hmac_msg_o, hmac_len_o} !== snap)) stab_err++;
      held_v = hmac_v_o && !req_x;
      snap   = {hmac_key_o, hmac_msg_o, hmac_len_o};
      if (req_x) begin
        if (busy) ost_err++;
        cap_key = hmac_key_o; cap_msg = hmac_msg_o; cap_len = hmac_len_o;
      end
      @(posedge clk_i);
      #1;
      if (!rst_ni) begin
        busy = 1'b0; held_v = 1'b0; hmac_v_i = 1'b0; hmac_r_i = 1'b0;
      end else begin
        if (res_x) begin
          hmac_v_i = 1'b0; busy = 1'b0; n_res++;
        end
        if (req_x) begin
          busy = 1'b1;
          pend = hmac_ref(cap_key, cap_msg, cap_len);
          dly  = stall_mode ? int'($urandom_range(0, 4)) : lat_n;
          n_req++;
          log_msg.push_back(cap_msg);
          log_len.push_back(cap_len);
        end
        if (busy && !hmac_v_i) begin
          if (dly == 0) begin
            hmac_v_i = 1'b1; hmac_prf_i = pend;
          end else dly--;
        end
        hmac_r_i = busy ? 1'b0 : (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      end
    end
  end

  // ---------------- host-side tasks ----------------
  task automatic clear_counts();
    n_req = 0; n_res = 0; stab_err = 0; ost_err = 0; hold_err = 0; hv_seen = 0;
    log_msg.delete(); log_len.delete();
  endtask

  task automatic send_req(input logic [5:0] slen, input logic [ITER_W-1:0] iter,
                          input bit push, input logic exp_err, input logic [255:0] exp_dk);
    bit rdy;
    int n;
    exp_t e;
    @(posedge clk_i);
    #1;
    password_i = PW; salt_i = SALT; salt_len_i = slen; iter_i = iter; v_i = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk_i);
      rdy = r_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    check("req_accept", rdy, 1'b1);
    v_i = 1'b0;
    password_i = '1; salt_i = '1; salt_len_i = '1; iter_i = '1;
    acc_cyc = cyc;
    if (push) begin
      e.err = exp_err; e.dk = exp_dk;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_result(input string tag, input int budget, input bit hold);
    int n;
    logic [255:0] dk_s;
    logic err_s;
    exp_t e;
    n = 0;
    @(negedge clk_i);
    while (v_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "/v_o_timeout"}, v_o, 1'b1);
    last_lat = cyc - acc_cyc;
    if (hold) begin
      dk_s = dk_o; err_s = err_o;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk_i);
        if (v_o !== 1'b1 || dk_o !== dk_s || err_o !== err_s) hold_err++;
      end
      r_i = 1'b1;
    end
    check({tag, "/sb_nonempty"}, sb_q.size() > 0, 1'b1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "/dk"}, dk_o, e.dk);
      check({tag, "/err"}, err_o, e.err);
    end
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check({tag, "/back_to_idle"}, {v_o, r_o}, 2'b01);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/r_o"}, r_o, 1'b1);
    check({tag, "/v_o"}, v_o, 1'b0);
    check({tag, "/err_o"}, err_o, 1'b0);
    check({tag, "/dk_o"}, dk_o, 256'b0);
    check({tag, "/hmac_v_o"}, hmac_v_o, 1'b0);
    check({tag, "/hmac_r_o"}, hmac_r_o, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_ni = 1'b0; v_i = 1'b0; r_i = 1'b1;
    password_i = '0; salt_i = '0; salt_len_i = '0; iter_i = '0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // c = 1, zero-wait engine
    clear_counts();
    send_req(6'd4, 32'd1, 1'b1, 1'b0, DK_C1);
    wait_result("c1", 200, 1'b0);
    check("c1/latency", last_lat, 2);
    check("c1/n_req", n_req, 1);
    check("c1/len", (log_len.size() > 0) ? log_len[0] : 6'h3f, 6'd8);
    check("c1/msg", (log_msg.size() > 0) ? log_msg[0] : '1, {32'h73616c74, 32'h00000001, 448'b0});

    // c = 2: second request carries U1
    clear_counts();
    send_req(6'd4, 32'd2, 1'b1, 1'b0, DK_C2);
    wait_result("c2", 200, 1'b0);
    check("c2/latency", last_lat, 4);
    check("c2/n_req", n_req, 2);
    check("c2/len2", (log_len.size() > 1) ? log_len[1] : 6'h3f, 6'd32);
    check("c2/msg2", (log_msg.size() > 1) ? log_msg[1] : '1, {DK_C1, 256'b0});

    // c = 4096
    clear_counts();
    send_req(6'd4, 32'd4096, 1'b1, 1'b0, DK_C4096);
    wait_result("c4096", 20000, 1'b0);
    check("c4096/n_req", n_req, 4096);
    check("c4096/n_res", n_res, 4096);
    check("c4096/outstanding", ost_err, 0);

    // c = 2 with random engine stalls and a 10-cycle downstream back-pressure
    clear_counts();
    stall_mode = 1'b1;
    r_i = 1'b0;
    send_req(6'd4, 32'd2, 1'b1, 1'b0, DK_C2);
    wait_result("stall", 500, 1'b1);
    stall_mode = 1'b0;
    check("stall/req_stable", stab_err, 0);
    check("stall/hold", hold_err, 0);
    check("stall/outstanding", ost_err, 0);

    // illegal salt length: error, no HMAC traffic
    clear_counts();
    send_req(6'd52, 32'd3, 1'b1, 1'b1, 256'b0);
    wait_result("badlen", 50, 1'b0);
    check("badlen/n_req", n_req, 0);
    check("badlen/hmac_v_seen", hv_seen, 0);

    // iteration count 0 behaves as 1
    clear_counts();
    send_req(6'd4, 32'd0, 1'b1, 1'b0, DK_C1);
    wait_result("iter0", 200, 1'b0);
    check("iter0/n_req", n_req, 1);

    // asynchronous reset while waiting on iteration 3
    clear_counts();
    lat_n = 5;
    send_req(6'd4, 32'd4, 1'b0, 1'b0, 256'b0);
    n = 0;
    @(negedge clk_i);
    while (!(n_req == 3 && hmac_r_o === 1'b1) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    check("midreset/reached_wait3", {30'b0, n_req == 3, hmac_r_o}, 32'd3);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    lat_n = 0;
    repeat (2) @(negedge clk_i);
    clear_counts();
    send_req(6'd4, 32'd1, 1'b1, 1'b0, DK_C1);
    wait_result("post_reset", 200, 1'b0);
    check("post_reset/n_req", n_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pbkdf2_iter_ctrl.md
Name: pbkdf2_iter_ctrl

Overview:
Initiator side of the HMAC-SHA256 request/response interface. Runs one PBKDF2-HMAC-SHA256 output block (dkLen ≤ 32 bytes):
- U1 = HMAC(P, S || INT(1))
- Uj = HMAC(P, Uj-1)
- DK = U1 ^ U2 ^ ... ^ Uc

It sits between the host-facing key-derivation front end and a single HMAC-SHA256 engine. It issues requests, consumes results and accumulates the XOR.

Parameters:
ITER_W, 32, width of iteration count and internal iteration counter.

Ports:
clk_i  in  1  clock; all state on rising edge.
rst_ni  in  1  reset, asynchronous assert, active-low.
password_i  in  512  HMAC key, left aligned, zero padded on the right.
salt_i  in  512  salt, left aligned; bytes at or beyond salt_len_i are ignored (masked to zero).
salt_len_i  in  6  salt length in bytes; legal range 0..51.
iter_i  in  ITER_W  iteration count c; 0 is treated as 1.
v_i  in  1  request valid.
r_o  out  1  ready for request.
dk_o  out  256  derived key T1.
err_o  out  1  request had illegal salt_len_i; qualified by v_o.
v_o  out  1  result valid.
r_i  in  1  downstream ready.
hmac_key_o  out  512  key to HMAC engine.
hmac_msg_o  out  512  message to HMAC engine, left aligned.
hmac_len_o  out  6  message length in bytes.
hmac_v_o  out  1  HMAC request valid.
hmac_r_i  in  1  HMAC engine ready.
hmac_prf_i  in  256  HMAC result.
hmac_v_i  in  1  HMAC result valid.
hmac_r_o  out  1  ready for HMAC result.

Behaviour:
- Reset (rst_ni=0, async): state=IDLE.
  - r_o=1; v_o=0; err_o=0; dk_o=0.
  - hmac_v_o=0; hmac_r_o=0.
  - Counter, accumulator and U register cleared.
- Reset mid-operation aborts immediately. An HMAC transaction in flight is abandoned. The HMAC engine must be reset by the same reset.
- Handshakes are valid/ready. A transfer occurs on a rising edge with v&r both high.
- hmac_key_o, hmac_msg_o and hmac_len_o are stable while hmac_v_o=1.
- dk_o and err_o are stable while v_o=1.
- IDLE:
  - r_o=1.
  - On v_i, latch password, masked salt, salt_len, and iter (0 becomes 1). Clear acc=0; j=1.
  - If salt_len_i>51: go to DONE with err_o=1 and dk_o=0, with no HMAC traffic.
  - Otherwise go to SEND.
- SEND:
  - hmac_v_o=1; hmac_key_o=password latch.
  - If j==1: hmac_msg_o = salt | ({32'h00000001, 480'b0} >> 8*salt_len); hmac_len_o = salt_len+4 (max 55).
  - If j>1: hmac_msg_o = {U, 256'b0}; hmac_len_o = 32.
  - On hmac_r_i, go to WAIT.
- WAIT:
  - hmac_r_o=1.
  - On hmac_v_i: U<=hmac_prf_i; acc<=acc^hmac_prf_i.
  - If j==c, go to DONE. Otherwise j<=j+1 and go to SEND.
  - hmac_v_i outside WAIT is ignored (hmac_r_o=0).
- DONE:
  - v_o=1; dk_o=acc; err_o per latch.
  - On r_i, go to IDLE. r_o stays 0 until IDLE, so requests are not overlapped.
- Latency with a zero-wait HMAC engine (hmac_r_i=1, result N cycles after acceptance):
  - Request accept at edge 0; hmac_v_o high in the cycle after.
  - Each iteration takes 1 (SEND) + N+1 (WAIT) cycles.
  - v_o rises the cycle after the final result is accepted.
- Counter compare is j==c at full ITER_W width. c = 2^ITER_W-1 must complete with no wrap.
- One HMAC request is outstanding at most at any time.
- dk_o truncation to dkLen is the consumer's job.

Test Plan:
- P="password" (8 B), S="salt" (4 B), c=1 -> dk_o=120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b; exactly 1 HMAC request, hmac_len_o=8, msg prefix "salt"||00000001.
- Same P and S, c=2 -> dk_o=ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43; second request has hmac_len_o=32 and msg=U1.
- Same P and S, c=4096 -> dk_o=c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a; 4096 requests, 4096 results.
- Random stalls on hmac_r_i, delayed hmac_v_i, and r_i held low 10 cycles -> identical dk_o. Request fields stable while hmac_v_o is high; v_o and dk_o held until r_i.
- salt_len_i=52 -> v_o with err_o=1, dk_o=0, hmac_v_o never asserted. iter_i=0 -> same result as c=1.
- rst_ni low during WAIT of iteration 3 -> all outputs at reset values asynchronously. A new c=1 request afterwards yields the c=1 vector.
